// File: rtl/eth_phy_10g_rx_test_pattern_chk.sv
// 10GBASE-R RX test-pattern checker: descrambles 66b blocks, compares with cfg_pattern, counts errored blocks.
// Optional `ETH_PHY_TP_CHK_BIT_ERR_CNT_EN adds a 32-bit saturating bit-error counter (tp_bit_error_count).
module eth_phy_10g_rx_test_pattern_chk #(
  parameter int DATA_WIDTH        = 64,
  parameter int HDR_WIDTH         = 2,
  parameter int CNT_WIDTH         = 16,
  parameter int SYNC_BLOCKS       = 4,
  parameter int LOSS_BLOCKS       = 16,
  parameter int SCRAMBLER_DISABLE = 0
) (
  input  logic                  rx_clk,
  input  logic                  rx_rst_n,
  input  logic [DATA_WIDTH-1:0] serdes_rx_data,
  input  logic [HDR_WIDTH-1:0]  serdes_rx_hdr,
  input  logic                  rx_block_lock,
  input  logic                  cfg_enable,
  input  logic [DATA_WIDTH-1:0] cfg_pattern,
  input  logic                  cfg_clear,
  output logic                  tp_lock,
  output logic                  tp_bad_block,
  output logic [CNT_WIDTH-1:0]  tp_error_count
`ifdef ETH_PHY_TP_CHK_BIT_ERR_CNT_EN
  ,
  output logic [31:0]           tp_bit_error_count
`endif
);
  typedef enum logic [1:0] {ST_OFF, ST_FLUSH, ST_ACQ, ST_LOCKED} state_e;

  // Enable, block lock and clear ride along with their block so they act on the block they arrived with.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [HDR_WIDTH-1:0]  hdr;
    logic                  blk_lock;
    logic                  en;
    logic                  clr;
  } blk_t;

  localparam state_e RESYNC_ST = (SCRAMBLER_DISABLE != 0) ? ST_ACQ : ST_FLUSH;

  blk_t                  s0_d, s0_q, s1_d, s1_q;
  logic [57:0]           scr_d, scr_q;
  logic [DATA_WIDTH-1:0] desc;
  state_e                state_d, state_q;
  logic [7:0]            run_d, run_q;
  logic [8:0]            run_inc;
  logic [CNT_WIDTH-1:0]  cnt_d, cnt_q;
  logic                  lock_d, lock_q, bad_d, bad_q;
  logic                  good, lk_eval, inc;

  assign s0_d = {serdes_rx_data, serdes_rx_hdr, rx_block_lock, cfg_enable, cfg_clear};

  // Self-synchronising descrambler x^58+x^39+1; state always advances on raw input bits.
  always_comb begin
    scr_d = scr_q;
    desc  = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      desc[i] = s0_q.data[i] ^ scr_d[38] ^ scr_d[57];
      scr_d   = {scr_d[56:0], s0_q.data[i]};
    end
  end

  always_comb begin
    s1_d      = s0_q;
    s1_d.data = (SCRAMBLER_DISABLE != 0) ? s0_q.data : desc;
  end

  assign good    = (s1_q.hdr == HDR_WIDTH'(1)) && (s1_q.data == cfg_pattern);
  assign run_inc = {1'b0, run_q} + 9'd1;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    lk_eval = 1'b0;
    case (state_q)
      ST_OFF:   if (s1_q.en) state_d = RESYNC_ST;
      ST_FLUSH: state_d = ST_ACQ;
      ST_ACQ: begin
        if (!good) run_d = '0;
        else if (run_inc == 9'(SYNC_BLOCKS)) begin
          state_d = ST_LOCKED;
          run_d   = '0;
        end else run_d = run_inc[7:0];
      end
      default: begin
        lk_eval = 1'b1;
        if (good) run_d = '0;
        else if (run_inc == 9'(LOSS_BLOCKS)) begin
          state_d = ST_ACQ;
          run_d   = '0;
        end else run_d = run_inc[7:0];
      end
    endcase
    // Losing block lock or enable abandons the block outright; it is never counted.
    if (state_q != ST_OFF && !s1_q.blk_lock) begin
      state_d = RESYNC_ST;
      run_d   = '0;
      lk_eval = 1'b0;
    end
    if (!s1_q.en) begin
      state_d = ST_OFF;
      run_d   = '0;
      lk_eval = 1'b0;
    end
    inc    = lk_eval && !good;
    bad_d  = inc;
    lock_d = (state_d == ST_LOCKED);
    cnt_d  = cnt_q;
    if (s1_q.clr) cnt_d = inc ? CNT_WIDTH'(1) : '0;
    else if (inc && cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      s0_q    <= '0;
      s1_q    <= '0;
      scr_q   <= '0;
      state_q <= ST_OFF;
      run_q   <= '0;
      cnt_q   <= '0;
      lock_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      scr_q   <= scr_d;
      state_q <= state_d;
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      lock_q  <= lock_d;
      bad_q   <= bad_d;
    end
  end

  assign tp_lock        = lock_q;
  assign tp_bad_block   = bad_q;
  assign tp_error_count = cnt_q;

`ifdef ETH_PHY_TP_CHK_BIT_ERR_CNT_EN
  logic [6:0]  pop;
  logic [31:0] add, bits_d, bits_q;
  logic [32:0] bsum;

  // A bad sync header is charged as two bit errors on top of payload mismatches.
  always_comb begin
    pop = '0;
    for (int i = 0; i < DATA_WIDTH; i++) pop = pop + 7'(s1_q.data[i] ^ cfg_pattern[i]);
    if (s1_q.hdr != HDR_WIDTH'(1)) pop = pop + 7'd2;
    add  = lk_eval ? 32'(pop) : 32'd0;
    bsum = {1'b0, bits_q} + {1'b0, add};
    if (s1_q.clr) bits_d = add;
    else bits_d = bsum[32] ? 32'hFFFF_FFFF : bsum[31:0];
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) bits_q <= '0;
    else bits_q <= bits_d;
  end

  assign tp_bit_error_count = bits_q;
`endif
endmodule
